muldiv_64: RTL and testbench

MULDIV_64 -- requirements
Module: muldiv_64

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_64.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_64.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN  = 64;
    // Wide enough to hold the iteration count XLEN itself.
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_t;

    // funct3[2] separates the divide/remainder group from the multiplies.
    function automatic logic is_div(input muldiv_op_t o);
        return o[2];
    endfunction

endpackage

// File: rtl/muldiv_64.sv
// Iterative RV64M multiply/divide unit, one bit per cycle on operand
// magnitudes with a final sign correction.
// Build option: MULDIV_DIV_EN enables the restoring divider (ops 4-7);
// without it those ops complete immediately with no register write.
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | XLEN shift iterations, then one cycle to sign-correct the result
// DONE   | result presented for one cycle; start here is accepted
module muldiv_64
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic            reg_write,
    output logic [4:0]      w_reg,
    output logic [XLEN-1:0] w_data
);

    muldiv_state_t   state_q;
    muldiv_op_t      op_q;
    logic [4:0]      rd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0] opnd_q;
    logic [CNT_W-1:0] cnt_q;
    logic            neg_q;
    logic            busy_q, done_q, reg_write_q;
    logic [4:0]      w_reg_q;
    logic [XLEN-1:0] w_data_q;

    muldiv_op_t      op_in;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            short_cut, short_we;
    logic [XLEN-1:0] short_data;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] step_next, prod_s;
    logic [XLEN-1:0] fin;

`ifdef MULDIV_DIV_EN
    logic            rneg_q;
    logic            div_zero, div_ovf;
    logic [XLEN:0]   div_sh;
    logic [XLEN-1:0] div_sub;
`endif

    // Decode the incoming request: operand signs, magnitudes and short-circuits.
    always_comb begin
        op_in = muldiv_op_t'(op);
        a_neg = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_data[XLEN-1];
        b_neg = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && rs2_data[XLEN-1];
        a_mag = a_neg ? -rs1_data : rs1_data;
        b_mag = b_neg ? -rs2_data : rs2_data;
`ifdef MULDIV_DIV_EN
        div_zero   = is_div(op_in) && (rs2_data == '0);
        div_ovf    = (op_in inside {OP_DIV, OP_REM}) &&
                     (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        short_cut  = div_zero || div_ovf;
        short_we   = 1'b1;
        short_data = '0;
        if (div_zero)
            short_data = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : rs1_data;
        else if (div_ovf)
            short_data = (op_in == OP_DIV) ? rs1_data : '0;
`else
        short_cut  = is_div(op_in);
        short_we   = 1'b0;
        short_data = '0;
`endif
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        step_next = {mul_sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_sub = div_sh[XLEN-1:0] - opnd_q;
        if (is_div(op_q)) begin
            if (div_sh >= {1'b0, opnd_q})
                step_next = {div_sub, acc_q[XLEN-2:0], 1'b1};
            else
                step_next = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
`endif
    end

    // Sign-correct and select the result once the iterations are finished.
    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        fin    = '0;
        case (op_q)
            OP_MUL:                        fin = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:  fin = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            OP_REM, OP_REMU:  fin = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`endif
            default:                       fin = '0;
        endcase
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            rd_q        <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
`ifdef MULDIV_DIV_EN
            rneg_q      <= 1'b0;
`endif
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            w_reg_q     <= '0;
            w_data_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q  <= op_in;
                        rd_q  <= rd;
                        neg_q <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                        rneg_q <= a_neg;
`endif
                        if (short_cut) begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            w_reg_q     <= rd;
                            w_data_q    <= short_data;
                            reg_write_q <= short_we && (rd != 5'd0);
                        end else begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(XLEN);
`ifdef MULDIV_DIV_EN
                            if (is_div(op_in)) begin
                                acc_q  <= {{XLEN{1'b0}}, a_mag};
                                opnd_q <= b_mag;
                            end else begin
                                acc_q  <= {{XLEN{1'b0}}, b_mag};
                                opnd_q <= a_mag;
                            end
`else
                            acc_q  <= {{XLEN{1'b0}}, b_mag};
                            opnd_q <= a_mag;
`endif
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        acc_q <= step_next;
                    end else begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        w_reg_q     <= rd_q;
                        w_data_q    <= fin;
                        reg_write_q <= (rd_q != 5'd0);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_write = reg_write_q;
    assign w_reg     = w_reg_q;
    assign w_data    = w_data_q;

endmodule

// File: tb/tb_muldiv_64.sv
// Directed self-checking bench for muldiv_64. Latency is counted in clock
// edges after the accepting edge: 65 for iterative ops, 0 for short-circuits
// (done already high in the cycle right after the start cycle).
module tb_muldiv_64;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [63:0] rs1_data, rs2_data;
    logic        busy, done, reg_write;
    logic [4:0]  w_reg;
    logic [63:0] w_data;

    int passed = 0;
    int total  = 0;

    muldiv_64 dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .busy(busy), .done(done),
        .reg_write(reg_write), .w_reg(w_reg), .w_data(w_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one op from a point just after a clock edge, scramble the inputs
    // after acceptance, and wait (bounded) for done.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [4:0] r,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_data, input logic exp_we, input int exp_lat);
        int n;
        start = 1'b1; op = o; rd = r; rs1_data = a; rs2_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; rd = ~r; rs1_data = ~a; rs2_data = b ^ 64'h5A5A;
        check({tag, ".busy"}, {63'd0, busy}, {63'd0, exp_lat != 0});
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".done"}, {63'd0, done}, 64'd1);
        check({tag, ".lat"}, 64'(n), 64'(exp_lat));
        check({tag, ".data"}, w_data, exp_data);
        check({tag, ".wreg"}, {59'd0, w_reg}, {59'd0, r});
        check({tag, ".we"}, {63'd0, reg_write}, {63'd0, exp_we});
    endtask

    initial begin
        int n, pulses;
        reset = 1'b1; start = 1'b0; op = '0; rd = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", {63'd0, busy}, 64'd0);
        check("rst.done", {63'd0, done}, 64'd0);
        check("rst.we", {63'd0, reg_write}, 64'd0);
        check("rst.wreg", {59'd0, w_reg}, 64'd0);
        check("rst.data", w_data, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("mul", 3'd0, 5'd5, 64'd7, -64'sd3, -64'sd21, 1'b1, 65);
        @(posedge clk); #1;
        check("mul.done_clr", {63'd0, done}, 64'd0);
        check("mul.we_clr", {63'd0, reg_write}, 64'd0);
        check("mul.data_hold", w_data, -64'sd21);

        run_op("mulhu", 3'd3, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 65);
        @(posedge clk); #1;
        run_op("mulh", 3'd1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 1'b1, 65);
        @(posedge clk); #1;
        run_op("mulhsu", 3'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65);
        @(posedge clk); #1;
        run_op("mul_rd0", 3'd0, 5'd0, 64'd3, 64'd4, 64'd12, 1'b0, 65);
        @(posedge clk); #1;

`ifdef MULDIV_DIV_EN
        run_op("div", 3'd4, 5'd10, -64'sd20, 64'd3, -64'sd6, 1'b1, 65);
        @(posedge clk); #1;
        run_op("rem", 3'd6, 5'd11, -64'sd20, 64'd3, -64'sd2, 1'b1, 65);
        @(posedge clk); #1;
        run_op("divu", 3'd5, 5'd12, 64'd100, 64'd7, 64'd14, 1'b1, 65);
        @(posedge clk); #1;
        run_op("remu", 3'd7, 5'd13, 64'd100, 64'd7, 64'd2, 1'b1, 65);
        @(posedge clk); #1;
        run_op("divu0", 3'd5, 5'd14, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        @(posedge clk); #1;
        run_op("rem0", 3'd6, 5'd15, 64'd55, 64'd0, 64'd55, 1'b1, 0);
        @(posedge clk); #1;
        run_op("div_ovf", 3'd4, 5'd16, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b1, 0);
        @(posedge clk); #1;
        run_op("rem_ovf", 3'd6, 5'd17, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 1'b1, 0);
        @(posedge clk); #1;
`else
        run_op("div_off", 3'd4, 5'd3, -64'sd20, 64'd3, 64'd0, 1'b0, 0);
        @(posedge clk); #1;
        run_op("remu_off", 3'd7, 5'd4, 64'd100, 64'd7, 64'd0, 1'b0, 0);
        @(posedge clk); #1;
`endif

        // Back-to-back: the second start is presented during the DONE cycle.
        run_op("b2b_a", 3'd0, 5'd2, 64'd2, 64'd3, 64'd6, 1'b1, 65);
        run_op("b2b_b", 3'd0, 5'd9, 64'd5, 64'd5, 64'd25, 1'b1, 65);
        @(posedge clk); #1;

        // A start pulse during CALC is ignored and produces no extra done.
        start = 1'b1; op = 3'd0; rd = 5'd4; rs1_data = 64'd6; rs2_data = 64'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; op = 3'd0; rd = 5'd8; rs1_data = 64'd1; rs2_data = 64'd1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 10;
        while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        check("ign.lat", 64'(n), 64'd65);
        check("ign.data", w_data, 64'd42);
        check("ign.wreg", {59'd0, w_reg}, 64'd4);
        pulses = 0;
        repeat (70) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
        check("ign.extra_done", 64'(pulses), 64'd0);

        // Reset 30 cycles into an operation aborts it.
        start = 1'b1; op = 3'd0; rd = 5'd6; rs1_data = 64'd9; rs2_data = 64'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort.busy", {63'd0, busy}, 64'd0);
        check("abort.done", {63'd0, done}, 64'd0);
        check("abort.we", {63'd0, reg_write}, 64'd0);
        check("abort.wreg", {59'd0, w_reg}, 64'd0);
        check("abort.data", w_data, 64'd0);
        reset = 1'b0;
        pulses = 0;
        repeat (80) begin @(posedge clk); #1; if (done === 1'b1 || reg_write === 1'b1) pulses++; end
        check("abort.no_done", 64'(pulses), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
